// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Oversampling asynchronous serial receiver: one start bit, N data bits
//   (LSB first), one stop bit. Reassembled words are offered on a
//   valid/ready interface that feeds a parallel-load shift register.
// Ports:
//   clk        rising-edge clock
//   n_reset    asynchronous active-low reset
//   rxd        serial line (asynchronous, idles high)
//   data_out   last received word, stable while valid is high
//   valid      data_out holds an unconsumed word
//   ready      downstream accepts the word
//   frame_err  one-cycle pulse when a sampled stop bit is 0
//   overrun    one-cycle pulse when a good frame is dropped (valid && !ready)
module serial_frame_receiver #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         rxd,
  output logic [N-1:0] data_out,
  output logic         valid,
  input  logic         ready,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(N + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [N-1:0]   asm_q;
  logic           sync1, rx;

  // decoded strobes
  logic start_mid, bit_end, data_smp, stop_smp, good_stop, bad_stop;
  logic load, drop;

  // Two-flop synchronizer; both flops reset to the idle level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx    <= sync1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx) state_nxt = S_START;
      S_START: if (cnt == HALF_LAST) state_nxt = rx ? S_IDLE : S_DATA;
      S_DATA:  if (cnt == BIT_LAST && idx == IDX_LAST) state_nxt = S_STOP;
      S_STOP:  if (cnt == BIT_LAST) state_nxt = rx ? S_IDLE : S_BREAK;
      S_BREAK: if (rx) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    start_mid = (state == S_START) && (cnt == HALF_LAST);
    bit_end   = (cnt == BIT_LAST);
    data_smp  = (state == S_DATA) && bit_end;
    stop_smp  = (state == S_STOP) && bit_end;
    good_stop = stop_smp && rx;
    bad_stop  = stop_smp && !rx;
    // A good word loads if the slot is free or is being emptied this edge.
    load      = good_stop && (!valid || ready);
    drop      = good_stop && valid && !ready;
  end

  // Bit timing and assembly
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt   <= '0;
      idx   <= '0;
      asm_q <= '0;
    end else begin
      case (state)
        S_START:        cnt <= start_mid ? '0 : cnt + 1'b1;
        S_DATA, S_STOP: cnt <= bit_end   ? '0 : cnt + 1'b1;
        default:        cnt <= '0;
      endcase
      if (state == S_START)
        idx <= '0;
      else if (data_smp)
        idx <= idx + 1'b1;
      // Shift in at the MSB so the first (LSB) bit ends up in bit 0.
      if (data_smp)
        asm_q <= (asm_q >> 1) | (N'(rx) << (N - 1));
    end
  end

  // Parallel output and status pulses; the handshake runs independently of
  // the receive state.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= drop;
      if (load) begin
        data_out <= asm_q;
        valid    <= 1'b1;
      end else if (ready) begin
        valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
//   Directed bench for serial_frame_receiver with default parameters.
//   A negedge monitor records when valid rises/falls and when the status
//   pulses fire, as absolute clock-edge numbers; tests compare those against
//   edge numbers computed from P (first edge that captures the start bit).
module tb_serial_frame_receiver;

  localparam int N = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         rxd = 1'b1;
  logic         ready = 1'b1;
  logic [N-1:0] data_out;
  logic         valid, frame_err, overrun;

  int checks = 0;
  int failures = 0;

  serial_frame_receiver #(.N(N), .CLKS_PER_BIT(D)) dut (
    .clk(clk), .n_reset(n_reset), .rxd(rxd), .data_out(data_out),
    .valid(valid), .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // edge counter: after rising edge k, cyc == k
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  int vrise_n = 0, vrise_cyc = 0, vfall_n = 0, vfall_cyc = 0;
  int ferr_n = 0, ferr_cyc = 0, ovr_n = 0, ovr_cyc = 0, both_n = 0;
  logic [N-1:0] vrise_data = '0;
  logic valid_q = 1'b0;
  always @(negedge clk) begin
    if (valid && !valid_q) begin vrise_n++; vrise_cyc = cyc; vrise_data = data_out; end
    if (!valid && valid_q) begin vfall_n++; vfall_cyc = cyc; end
    valid_q = valid;
    if (frame_err) begin ferr_n++; ferr_cyc = cyc; end
    if (overrun)   begin ovr_n++;  ovr_cyc  = cyc; end
    if (frame_err && overrun) both_n++;
  end

  int p;

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (D) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < N; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int v0;
    #2;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data got %h want 00", data_out); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_pulses got %b%b want 00", frame_err, overrun); end
    @(posedge clk); @(posedge clk); #1;
    n_reset = 1'b1;
    idle(4);
    // load a word that the mid-frame reset must clear
    ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(2);
    checks++; if (valid !== 1'b1 || data_out !== 8'h5A) begin failures++; $display("FAIL pre_abort got v=%b d=%h want v=1 d=5a", valid, data_out); end
    // start 0xA5, reset during data bit 2
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    n_reset = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL async_rst got v=%b d=%h want v=0 d=00", valid, data_out); end
    rxd = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_reset = 1'b1;
    ready = 1'b1;
    v0 = vrise_n;
    idle(D * 6);
    checks++; if (vrise_n !== v0) begin failures++; $display("FAIL abort_partial got rises=%0d want %0d", vrise_n, v0); end
    send_frame(8'h3C, 1'b1);
    idle(4);
    checks++; if (vrise_n !== v0 + 1 || vrise_data !== 8'h3C) begin failures++; $display("FAIL post_rst got n=%0d d=%h want n=%0d d=3c", vrise_n, vrise_data, v0 + 1); end
  endtask

  task automatic test_nominal;
    p = cyc + 1;
    send_frame(8'hA5, 1'b1);
    idle(4);
    checks++; if (vrise_cyc !== p + 154) begin failures++; $display("FAIL nom_rise got %0d want %0d", vrise_cyc, p + 154); end
    checks++; if (vrise_data !== 8'hA5) begin failures++; $display("FAIL nom_data got %h want a5", vrise_data); end
    checks++; if (vfall_cyc !== p + 155) begin failures++; $display("FAIL nom_fall got %0d want %0d", vfall_cyc, p + 155); end
  endtask

  task automatic test_glitch;
    int v0, f0, pg;
    v0 = vrise_n; f0 = ferr_n;
    pg = cyc + 1;
    rxd = 1'b0;
    repeat (4) @(posedge clk); #1;   // low on edges P..P+3
    idle(5);                         // high on edges P+4..P+8
    // next start captured at P+9: only works if the FSM is back in IDLE
    // by E0+8 = P+10
    p = cyc + 1;
    checks++; if (p !== pg + 9) begin failures++; $display("FAIL glitch_setup got %0d want %0d", p, pg + 9); end
    send_frame(8'h96, 1'b1);
    idle(4);
    checks++; if (vrise_n !== v0 + 1 || vrise_data !== 8'h96) begin failures++; $display("FAIL glitch_word got n=%0d d=%h want n=%0d d=96", vrise_n, vrise_data, v0 + 1); end
    checks++; if (vrise_cyc !== p + 154) begin failures++; $display("FAIL glitch_time got %0d want %0d", vrise_cyc, p + 154); end
    checks++; if (ferr_n !== f0) begin failures++; $display("FAIL glitch_ferr got %0d want %0d", ferr_n, f0); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = vrise_n; f0 = ferr_n;
    p = cyc + 1;
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (40) @(posedge clk); #1;
    idle(D);
    checks++; if (ferr_n !== f0 + 1) begin failures++; $display("FAIL ferr_count got %0d want %0d", ferr_n, f0 + 1); end
    checks++; if (ferr_cyc !== p + 154) begin failures++; $display("FAIL ferr_time got %0d want %0d", ferr_cyc, p + 154); end
    checks++; if (vrise_n !== v0) begin failures++; $display("FAIL ferr_valid got rises=%0d want %0d", vrise_n, v0); end
    p = cyc + 1;
    send_frame(8'h55, 1'b1);
    idle(4);
    checks++; if (vrise_n !== v0 + 1 || vrise_data !== 8'h55) begin failures++; $display("FAIL ferr_next got n=%0d d=%h want n=%0d d=55", vrise_n, vrise_data, v0 + 1); end
    checks++; if (vrise_cyc !== p + 154 || ferr_n !== f0 + 1) begin failures++; $display("FAIL ferr_next_time got %0d/%0d want %0d/%0d", vrise_cyc, ferr_n, p + 154, f0 + 1); end
  endtask

  task automatic test_overrun;
    int v0, o0;
    ready = 1'b0;
    v0 = vrise_n; o0 = ovr_n;
    send_frame(8'h11, 1'b1);
    p = cyc + 1;
    send_frame(8'h22, 1'b1);
    idle(4);
    checks++; if (ovr_n !== o0 + 1 || ovr_cyc !== p + 154) begin failures++; $display("FAIL ovr_pulse got n=%0d t=%0d want n=%0d t=%0d", ovr_n, ovr_cyc, o0 + 1, p + 154); end
    checks++; if (data_out !== 8'h11 || valid !== 1'b1) begin failures++; $display("FAIL ovr_keep got d=%h v=%b want d=11 v=1", data_out, valid); end
    checks++; if (vrise_n !== v0 + 1) begin failures++; $display("FAIL ovr_rises got %0d want %0d", vrise_n, v0 + 1); end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got %b want 0", valid); end
  endtask

  task automatic test_simultaneous;
    int o0, f0;
    ready = 1'b0;
    send_frame(8'h44, 1'b1);
    idle(2);
    checks++; if (valid !== 1'b1 || data_out !== 8'h44) begin failures++; $display("FAIL sim_pre got v=%b d=%h want v=1 d=44", valid, data_out); end
    o0 = ovr_n; f0 = vfall_n;
    p = cyc + 1;
    fork
      send_frame(8'h77, 1'b1);
      begin
        wait (cyc == p + 153); #1;
        ready = 1'b1;
        wait (cyc == p + 154); #1;
        ready = 1'b0;
      end
    join
    idle(2);
    checks++; if (data_out !== 8'h77 || valid !== 1'b1) begin failures++; $display("FAIL sim_load got d=%h v=%b want d=77 v=1", data_out, valid); end
    checks++; if (ovr_n !== o0) begin failures++; $display("FAIL sim_ovr got %0d want %0d", ovr_n, o0); end
    checks++; if (vfall_n !== f0) begin failures++; $display("FAIL sim_vfall got %0d want %0d", vfall_n, f0); end
    ready = 1'b1;
    idle(2);
    checks++; if (both_n !== 0) begin failures++; $display("FAIL both_pulses got %0d want 0", both_n); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_simultaneous;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receives asynchronous serial frames (one start bit, N data bits LSB first, one stop bit) on a single line. It oversamples the line with a fixed clock divisor, reassembles each data word, and presents it on a valid/ready parallel output. The block sits directly upstream of the team's parallel-load shift register: `data_out` feeds that register's `pdatain`, and a `valid && ready` transfer drives its `load`.

## Interface
- `N`, default 8: data bits per frame. Range 1–16.
- `CLKS_PER_BIT`, default 16: clock cycles per bit period (D). Must be even and ≥ 4.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `n_reset` in 1: reset, asynchronous, active-low.
- `rxd` in 1: serial line, asynchronous to `clk`. Idles high.
- `data_out` out N: last received word. Stable while `valid` is high.
- `valid` out 1: `data_out` holds an unconsumed word.
- `ready` in 1: downstream accepts the word.
- `frame_err` out 1: one-cycle pulse when a sampled stop bit is 0.
- `overrun` out 1: one-cycle pulse when a good frame is dropped because `valid && !ready`.

## Operation
- Input path: `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronizer output `rx`.
- State machine: IDLE, START, DATA, STOP, BREAK. A bit counter `cnt` (width `clog2(D)`) and a bit index `idx` (width `clog2(N+1)`) track position.
- IDLE: when `rx==0`, go to START with `cnt<=0`.
- START: increment `cnt` each cycle. On the edge where `cnt==D/2-1` (mid start bit):
  - if `rx==0`, go to DATA with `cnt<=0` and `idx<=0`;
  - otherwise treat it as a glitch and go to IDLE with no output.
- DATA: increment `cnt`. On the edge where `cnt==D-1`, sample `rx`, shift it into the assembly register at the MSB (shift right, so LSB arrives first), set `cnt<=0`, and `idx++`. After the N-th sample, go to STOP.
- STOP: increment `cnt`. On the edge where `cnt==D-1`, sample `rx`:
  - `rx==1` and (`!valid` or `ready`): `data_out<=assembly`, `valid<=1`, go to IDLE.
  - `rx==1` and `valid && !ready`: drop the new word, keep `data_out`, pulse `overrun`, go to IDLE.
  - `rx==0`: pulse `frame_err`, do not update `data_out`/`valid`, go to BREAK.
- BREAK: wait until `rx==1`, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Handshake: on an edge with `valid && ready` and no new word landing, `valid<=0`. If a good stop bit is sampled on the same edge as a `valid && ready` transfer, the new word loads and `valid` stays 1; this is not an overrun.
- `valid` and `data_out` are independent of the receive state machine: a handshake may complete during any state.

## Timing
- Reset values: `data_out=0`, `valid=0`, `frame_err=0`, `overrun=0`, state IDLE, `cnt=0`, `idx=0`, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No partial word is ever presented.
- Define P as the edge at which the first synchronizer flop captures `rxd` low. IDLE sees `rx==0` at edge E0 = P+2.
- Sample points:
  - start bit sampled at E0 + D/2;
  - data bit k (0..N-1) sampled at E0 + D/2 + (k+1)·D;
  - stop bit sampled at E0 + D/2 + (N+1)·D.
- `valid`, `frame_err` and `overrun` change on the stop-sample edge. With the defaults, this is P+154.
- The earliest next start is detected at the edge after return to IDLE, so back-to-back frames with a one-bit stop are supported.
- `frame_err` and `overrun` are never high together, and each is high for exactly one cycle.

## Test plan
- Reset: drive frame 0xA5 and assert `n_reset` low mid-data bits. Outputs go to reset values asynchronously. After release, frame 0x3C produces `data_out=0x3C`, `valid=1`.
- Nominal (defaults, `ready=1`): 0xA5 LSB first → `valid` rises at P+154 for exactly 1 cycle with `data_out=0xA5`.
- Glitch: `rxd` low for 4 cycles, then high → no `valid`, no `frame_err`; FSM returns to IDLE at E0+8.
- Frame error: 0x3C with stop bit 0, line held low for 40 cycles, then high, then frame 0x55:
  - `frame_err` pulses once at the stop sample, `valid` stays 0;
  - no false start is detected during the low period;
  - `data_out=0x55` then appears with `valid`.
- Overrun (`ready=0`): frames 0x11 then 0x22 back to back:
  - `data_out` stays 0x11;
  - `overrun` pulses at the second stop sample.
  - Asserting `ready` for 1 cycle drops `valid`.
- Simultaneous events: `ready` held 0, then raised exactly on the stop-sample edge of the next frame 0x77 → `data_out=0x77`, `valid` stays 1, no `overrun`.
